// File: rtl/zxbus_pkg.sv
// Shared constants for the GS mailbox host-side slave: default port map,
// status filler bits and the idle bus value.
package zxbus_pkg;
    localparam logic [7:0] DATA_PORT_DEF   = 8'hB3;
    localparam logic [7:0] CMD_PORT_DEF    = 8'hBB;
    localparam logic [7:0] RST_PORT_DEF    = 8'h33;
    localparam logic [5:0] STATUS_FILL     = 6'b111111;
    localparam logic [7:0] BUS_IDLE        = 8'hFF;
endpackage

// File: rtl/zxbus_strobe_sync.sv
// Three-flop synchroniser for an asynchronous ZX access strobe, with a
// single-cycle rising-edge event taken from the settled stages.
module zxbus_strobe_sync (
    input  logic cpu_clock,
    input  logic rst_n,
    input  logic strobe,
    output logic rise
);
    logic s1, s2, s3;

    // Preset to 1 so a strobe already active at reset release is not an edge.
    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= strobe;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
endmodule

// File: rtl/zxbus_slave.sv
// Host-side end of the GS mailbox: ZX port decode, command/data capture,
// shared handshake flags and the combinational ZX read mux.
module zxbus_slave
    import zxbus_pkg::*;
#(
    parameter logic [7:0] DATA_PORT = DATA_PORT_DEF,
    parameter logic [7:0] CMD_PORT  = CMD_PORT_DEF,
    parameter logic [7:0] RST_PORT  = RST_PORT_DEF
) (
    input  logic       cpu_clock,
    input  logic       rst_n,
    input  logic [7:0] zx_a,
    input  logic       zx_iorq_n,
    input  logic       zx_rd_n,
    input  logic       zx_wr_n,
    input  logic [7:0] zx_d_in,
    output logic [7:0] zx_d_out,
    output logic       zx_d_oe,
    input  logic [7:0] data_port_output,
    input  logic       data_bit_output,
    input  logic       data_bit_wr,
    input  logic       command_bit_output,
    input  logic       command_bit_wr,
    output logic [7:0] data_port_input,
    output logic [7:0] command_port_input,
    output logic       data_bit_input,
    output logic       command_bit_input,
    output logic       zx_rst_req
);
    logic rd_acc, wr_acc;
    logic rd_ev, wr_ev;
    logic sel_data, sel_cmd, sel_rst;
    logic wr_data, wr_cmd, wr_rst, rd_data;

    assign rd_acc = ~zx_iorq_n & ~zx_rd_n;
    assign wr_acc = ~zx_iorq_n & ~zx_wr_n;

    zxbus_strobe_sync u_rd_sync (
        .cpu_clock (cpu_clock),
        .rst_n     (rst_n),
        .strobe    (rd_acc),
        .rise      (rd_ev)
    );

    zxbus_strobe_sync u_wr_sync (
        .cpu_clock (cpu_clock),
        .rst_n     (rst_n),
        .strobe    (wr_acc),
        .rise      (wr_ev)
    );

    assign sel_data = (zx_a == DATA_PORT);
    assign sel_cmd  = (zx_a == CMD_PORT);
    assign sel_rst  = (zx_a == RST_PORT);

    // Address and data have been stable on the pins for two cycles by the
    // time the event fires, so they are captured directly. A write wins
    // over a concurrent read.
    assign wr_data = wr_ev & sel_data;
    assign wr_cmd  = wr_ev & sel_cmd;
    assign wr_rst  = wr_ev & sel_rst & zx_d_in[7];
    assign rd_data = rd_ev & ~wr_ev & sel_data;

    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            data_port_input    <= 8'h00;
            command_port_input <= 8'h00;
            zx_rst_req         <= 1'b0;
        end else begin
            if (wr_data) data_port_input    <= zx_d_in;
            if (wr_cmd)  command_port_input <= zx_d_in;
            zx_rst_req <= wr_rst;
        end
    end

    // Host events take priority over Z80 strobes so no handshake is lost.
    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            data_bit_input    <= 1'b0;
            command_bit_input <= 1'b0;
        end else begin
            if (wr_data)          data_bit_input <= 1'b1;
            else if (rd_data)     data_bit_input <= 1'b0;
            else if (data_bit_wr) data_bit_input <= data_bit_output;

            if (wr_cmd)              command_bit_input <= 1'b1;
            else if (command_bit_wr) command_bit_input <= command_bit_output;
        end
    end

    always_comb begin
        zx_d_out = BUS_IDLE;
        zx_d_oe  = 1'b0;
        if (rd_acc && sel_data) begin
            zx_d_out = data_port_output;
            zx_d_oe  = 1'b1;
        end else if (rd_acc && sel_cmd) begin
            zx_d_out = {data_bit_input, STATUS_FILL, command_bit_input};
            zx_d_oe  = 1'b1;
        end
    end
endmodule

// File: tb/tb_zxbus_slave.sv
// Directed self-checking bench for zxbus_slave: decode, capture latency,
// flag arbitration, reset-port pulse and reset-held strobe.
`timescale 1ns/1ps
module tb_zxbus_slave;
    logic       cpu_clock = 1'b0;
    logic       rst_n;
    logic [7:0] zx_a;
    logic       zx_iorq_n, zx_rd_n, zx_wr_n;
    logic [7:0] zx_d_in;
    logic [7:0] zx_d_out;
    logic       zx_d_oe;
    logic [7:0] data_port_output;
    logic       data_bit_output, data_bit_wr;
    logic       command_bit_output, command_bit_wr;
    logic [7:0] data_port_input, command_port_input;
    logic       data_bit_input, command_bit_input;
    logic       zx_rst_req;

    int checks = 0;
    int failures = 0;

    always #5 cpu_clock = ~cpu_clock;

    zxbus_slave dut (
        .cpu_clock          (cpu_clock),
        .rst_n              (rst_n),
        .zx_a               (zx_a),
        .zx_iorq_n          (zx_iorq_n),
        .zx_rd_n            (zx_rd_n),
        .zx_wr_n            (zx_wr_n),
        .zx_d_in            (zx_d_in),
        .zx_d_out           (zx_d_out),
        .zx_d_oe            (zx_d_oe),
        .data_port_output   (data_port_output),
        .data_bit_output    (data_bit_output),
        .data_bit_wr        (data_bit_wr),
        .command_bit_output (command_bit_output),
        .command_bit_wr     (command_bit_wr),
        .data_port_input    (data_port_input),
        .command_port_input (command_port_input),
        .data_bit_input     (data_bit_input),
        .command_bit_input  (command_bit_input),
        .zx_rst_req         (zx_rst_req)
    );

    // Bus drivers: strobes change just after a falling edge.
    task automatic bus_idle();
        zx_iorq_n = 1'b1; zx_rd_n = 1'b1; zx_wr_n = 1'b1;
    endtask

    task automatic start_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge cpu_clock);
        zx_a = a; zx_d_in = d;
        zx_iorq_n = 1'b0; zx_wr_n = 1'b0;
    endtask

    task automatic start_rd(input logic [7:0] a);
        @(negedge cpu_clock);
        zx_a = a;
        zx_iorq_n = 1'b0; zx_rd_n = 1'b0;
    endtask

    task automatic finish_acc();
        repeat (3) @(posedge cpu_clock);
        @(negedge cpu_clock);
        bus_idle();
        repeat (4) @(posedge cpu_clock);
    endtask

    task automatic test_reset();
        start_rd(8'hBB);
        #1;
        checks++; if (zx_d_out !== 8'h7E) begin failures++; $display("FAIL reset_status got=%h exp=7e", zx_d_out); end
        checks++; if (zx_d_oe !== 1'b1) begin failures++; $display("FAIL reset_status_oe got=%b exp=1", zx_d_oe); end
        checks++; if (data_port_input !== 8'h00) begin failures++; $display("FAIL reset_dpi got=%h exp=00", data_port_input); end
        checks++; if (zx_rst_req !== 1'b0) begin failures++; $display("FAIL reset_rst_req got=%b exp=0", zx_rst_req); end
        finish_acc();
        start_rd(8'h00);
        #1;
        checks++; if (zx_d_oe !== 1'b0) begin failures++; $display("FAIL unsel_oe got=%b exp=0", zx_d_oe); end
        checks++; if (zx_d_out !== 8'hFF) begin failures++; $display("FAIL unsel_out got=%h exp=ff", zx_d_out); end
        finish_acc();
    endtask

    task automatic test_data_write();
        start_wr(8'hB3, 8'h5A);
        repeat (2) @(posedge cpu_clock);
        #1;
        checks++; if (data_bit_input !== 1'b0) begin failures++; $display("FAIL dwr_early_bit got=%b exp=0", data_bit_input); end
        @(posedge cpu_clock); #1;
        checks++; if (data_bit_input !== 1'b1) begin failures++; $display("FAIL dwr_bit got=%b exp=1", data_bit_input); end
        checks++; if (data_port_input !== 8'h5A) begin failures++; $display("FAIL dwr_dpi got=%h exp=5a", data_port_input); end
        finish_acc();
        @(posedge cpu_clock); #1;
        data_bit_output = 1'b0; data_bit_wr = 1'b1;
        @(posedge cpu_clock); #1;
        data_bit_wr = 1'b0;
        checks++; if (data_bit_input !== 1'b0) begin failures++; $display("FAIL z80_clear got=%b exp=0", data_bit_input); end
    endtask

    task automatic test_data_read();
        @(posedge cpu_clock); #1;
        data_bit_output = 1'b1; data_bit_wr = 1'b1;
        @(posedge cpu_clock); #1;
        data_bit_wr = 1'b0;
        start_rd(8'hBB);
        #1;
        checks++; if (zx_d_out !== 8'hFE) begin failures++; $display("FAIL status_dbit got=%h exp=fe", zx_d_out); end
        finish_acc();
        data_port_output = 8'hC3;
        start_rd(8'hB3);
        #1;
        checks++; if (zx_d_out !== 8'hC3 || zx_d_oe !== 1'b1) begin failures++; $display("FAIL rd_out got=%h/%b exp=c3/1", zx_d_out, zx_d_oe); end
        repeat (2) @(posedge cpu_clock);
        #1;
        checks++; if (data_bit_input !== 1'b1) begin failures++; $display("FAIL rd_early_bit got=%b exp=1", data_bit_input); end
        @(posedge cpu_clock); #1;
        checks++; if (data_bit_input !== 1'b0) begin failures++; $display("FAIL rd_clear got=%b exp=0", data_bit_input); end
        checks++; if (zx_d_out !== 8'hC3) begin failures++; $display("FAIL rd_out_late got=%h exp=c3", zx_d_out); end
        finish_acc();
    endtask

    task automatic test_cmd_collision();
        start_wr(8'hBB, 8'h21);
        repeat (2) @(posedge cpu_clock);
        #1;
        command_bit_output = 1'b0; command_bit_wr = 1'b1;
        @(posedge cpu_clock); #1;
        command_bit_wr = 1'b0;
        checks++; if (command_bit_input !== 1'b1) begin failures++; $display("FAIL cmd_collide got=%b exp=1", command_bit_input); end
        checks++; if (command_port_input !== 8'h21) begin failures++; $display("FAIL cmd_cpi got=%h exp=21", command_port_input); end
        finish_acc();
        start_rd(8'hBB);
        #1;
        checks++; if (zx_d_out !== 8'h7F) begin failures++; $display("FAIL status_cbit got=%h exp=7f", zx_d_out); end
        finish_acc();
    endtask

    task automatic test_rst_port();
        int pulses;
        pulses = 0;
        start_wr(8'h33, 8'h80);
        repeat (10) begin @(negedge cpu_clock); if (zx_rst_req === 1'b1) pulses++; end
        bus_idle();
        repeat (4) @(posedge cpu_clock);
        checks++; if (pulses != 1) begin failures++; $display("FAIL rst_pulse got=%0d exp=1", pulses); end
        pulses = 0;
        start_wr(8'h33, 8'h00);
        repeat (10) begin @(negedge cpu_clock); if (zx_rst_req === 1'b1) pulses++; end
        bus_idle();
        repeat (4) @(posedge cpu_clock);
        checks++; if (pulses != 0) begin failures++; $display("FAIL rst_nopulse got=%0d exp=0", pulses); end
    endtask

    task automatic test_other_addr();
        start_wr(8'h00, 8'hE7);
        finish_acc();
        checks++; if (data_port_input !== 8'h5A) begin failures++; $display("FAIL other_dpi got=%h exp=5a", data_port_input); end
        checks++; if (command_port_input !== 8'h21) begin failures++; $display("FAIL other_cpi got=%h exp=21", command_port_input); end
    endtask

    task automatic test_reset_hold();
        @(negedge cpu_clock);
        rst_n = 1'b0;
        zx_a = 8'hBB; zx_d_in = 8'h77;
        zx_iorq_n = 1'b0; zx_wr_n = 1'b0;
        repeat (2) @(negedge cpu_clock);
        rst_n = 1'b1;
        repeat (8) @(posedge cpu_clock);
        #1;
        checks++; if (command_bit_input !== 1'b0) begin failures++; $display("FAIL hold_cbit got=%b exp=0", command_bit_input); end
        checks++; if (command_port_input !== 8'h00) begin failures++; $display("FAIL hold_cpi got=%h exp=00", command_port_input); end
        @(negedge cpu_clock);
        bus_idle();
        repeat (4) @(posedge cpu_clock);
    endtask

    initial begin
        rst_n = 1'b0;
        bus_idle();
        zx_a = 8'h00; zx_d_in = 8'h00;
        data_port_output = 8'h00;
        data_bit_output = 1'b0; data_bit_wr = 1'b0;
        command_bit_output = 1'b0; command_bit_wr = 1'b0;
        repeat (3) @(negedge cpu_clock);
        rst_n = 1'b1;
        repeat (2) @(posedge cpu_clock);
        test_reset();
        test_data_write();
        test_data_read();
        test_cmd_collision();
        test_rst_port();
        test_other_addr();
        test_reset_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/zxbus_slave.md
# zxbus_slave

Host-side end of the GS mailbox. Decodes ZX Spectrum I/O accesses to the command, data and reset ports, and latches host-written command and data bytes. Owns the data and command flag bits, which both the ZX host and the Z80 side can set or clear. Resynchronises the asynchronous ZX bus into the `cpu_clock` domain and feeds the `data_port_input`, `command_port_input`, `data_bit_input` and `command_bit_input` signals consumed by the Z80 port block.

## Interface
Parameters:
- `DATA_PORT`, 8'hB3, ZX address of the data register (read and write).
- `CMD_PORT`, 8'hBB, ZX address of the command register (write) and status register (read).
- `RST_PORT`, 8'h33, ZX address of the reset/control register (write only).

Ports:
- `cpu_clock`  in  1  Z80/FPGA clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `zx_a`  in  8  ZX address bus A7..A0 (async).
- `zx_iorq_n`, `zx_rd_n`, `zx_wr_n`  in  1 each  ZX bus control signals (async).
- `zx_d_in`  in  8  ZX data bus in (async).
- `zx_d_out`  out  8  data driven to the ZX bus.
- `zx_d_oe`  out  1  ZX bus drive enable.
- `data_port_output`  in  8  byte written by the Z80, returned on ZX read of `DATA_PORT`.
- `data_bit_output`, `data_bit_wr`  in  1 each  Z80-side data flag value and 1-cycle write strobe.
- `command_bit_output`, `command_bit_wr`  in  1 each  Z80-side command flag value and 1-cycle write strobe.
- `data_port_input`  out  8  last byte the ZX wrote to `DATA_PORT`.
- `command_port_input`  out  8  last byte the ZX wrote to `CMD_PORT`.
- `data_bit_input`, `command_bit_input`  out  1 each  current flag values (synchronous).
- `zx_rst_req`  out  1  1-cycle pulse when the ZX writes `RST_PORT` with D7=1.

## Operation
- `rd_acc = ~zx_iorq_n & ~zx_rd_n`; `wr_acc = ~zx_iorq_n & ~zx_wr_n`.
- Each access signal passes through a 3-stage synchroniser (s1→s2→s3). An event fires on a cycle where `s2 & ~s3`.
- On a write event, capture `zx_a` and `zx_d_in` from the pins. They have been stable for at least 2 cycles by then.
- ZX write to `DATA_PORT`: `data_port_input <= zx_d_in`, data bit set to 1.
- ZX read of `DATA_PORT`: data bit cleared to 0 on the read event.
- ZX write to `CMD_PORT`: `command_port_input <= zx_d_in`, command bit set to 1.
- ZX write to `RST_PORT` with D7=1: `zx_rst_req` pulses for one cycle. D7=0 has no effect.
- Any other address produces no event and no state change.
- Read path is combinational from the pins and registers, so there is no synchroniser delay on reads:
  - `zx_d_oe = rd_acc & (zx_a==DATA_PORT | zx_a==CMD_PORT)`.
  - `DATA_PORT` read: `zx_d_out = data_port_output`.
  - `CMD_PORT` read: `zx_d_out = {data_bit, 6'b111111, command_bit}`.
  - When not selected, `zx_d_out` = 8'hFF.
- Z80 side: `data_bit_wr` loads `data_bit_output` into the data bit. `command_bit_wr` loads `command_bit_output` into the command bit.
- Simultaneous ZX event and Z80 strobe on the same bit: the ZX event wins, so no host handshake is lost.
- Simultaneous read and write events (bus fault): the write is processed and the read is ignored.

## Timing
- Reset values:
  - `data_port_input` = 0, `command_port_input` = 0.
  - both flag bits = 0.
  - `zx_rst_req` = 0.
  - synchroniser stages = 1, so a strobe held across reset release causes no event.
  - `zx_d_out`/`zx_d_oe` follow their combinational rules.
- ZX strobe assertion to register/flag update: 3 `cpu_clock` rising edges, with up to 1 cycle of sampling uncertainty.
- Minimum ZX strobe width: 4 `cpu_clock` periods. Shorter strobes may be missed.
- One event per strobe assertion. A new event requires deassertion observed at s2 first.
- Z80 strobe to flag update: next rising edge. The new value is visible on `data_bit_input`/`command_bit_input` and on the ZX status read at that edge.
- `zx_rst_req` is asserted in the cycle after the event edge, for exactly 1 cycle.
- Asserting `rst_n` mid-access aborts the event and clears all state immediately.

## Structure
- Package `zxbus_pkg`: default port addresses, status filler constant 6'b111111, idle bus value 8'hFF.
- Sub-module `zxbus_strobe_sync`: 3-FF synchroniser with preset-to-1 reset and a rising-edge event output. Instantiated twice, once for read and once for write.
- Top level holds the decode, capture registers, flag logic and read mux.

## Test plan
- After reset, ZX reads `CMD_PORT` → 8'h7E, `zx_d_oe`=1. ZX reads port 8'h00 → `zx_d_oe`=0.
- ZX writes 8'h5A to `DATA_PORT` → within 3 edges `data_port_input`=8'h5A and `data_bit_input`=1. Then Z80 `data_bit_wr` with value 0 → bit 0 on the next edge.
- Set `data_port_output`=8'hC3, ZX reads `DATA_PORT` → `zx_d_out`=8'hC3 throughout the read, data bit cleared 3 edges after read assertion.
- ZX writes 8'h21 to `CMD_PORT` while Z80 pulses `command_bit_wr`=1 with value 0 in the same event cycle → `command_bit_input`=1, `command_port_input`=8'h21.
- ZX writes 8'h80 to `RST_PORT` → one `zx_rst_req` pulse. ZX writes 8'h00 → no pulse.
- Hold a `wr_acc` to `CMD_PORT` across `rst_n` release → no event, `command_bit_input` stays 0.
